uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 10, data bits per frame, LSB first.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit period; even, >=4.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rx_line  input  1  serial line; idle high; asynchronous to clk.
REQ-006 SHALL have port data_ack  input  1  consumer acknowledge; clears data_ready.
REQ-007 SHALL have port rx_data  output  DATA_BITS  last good received word.
REQ-008 SHALL have port data_ready  output  1  level; rx_data holds an unacknowledged word.
REQ-009 SHALL have port Done  output  1  one-cycle pulse per good frame.
REQ-010 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a good frame lands while data_ready=1.

Function
REQ-013 SHALL pass rx_line through a 2-flop synchronizer, with both flops reset to 1; rx_s is the second flop.
REQ-014 SHALL implement the frame format as start(0), DATA_BITS data bits LSB first, and one stop bit(1).
REQ-015 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 SHALL, in IDLE, move to START with the bit counter cleared when rx_s=0.
REQ-017 SHALL, in START, count CLKS_PER_BIT/2 cycles and then check rx_s: if 0, go to DATA with counters cleared; if 1, treat it as a glitch and return to IDLE with no flags.
REQ-018 SHALL, in DATA, sample rx_s every CLKS_PER_BIT cycles (mid-bit), shift it in at index bit_idx, and go to STOP after DATA_BITS samples.
REQ-019 SHALL, in STOP, sample rx_s after CLKS_PER_BIT cycles.
REQ-020 SHALL, on a stop sample of 1, load rx_data with the shifted word, set data_ready, pulse Done, and go to IDLE, all in the next cycle.
REQ-021 SHALL, on a stop sample of 0, pulse frame_err, leave rx_data and data_ready unchanged, and go to WAIT_HIGH.
REQ-022 SHALL, in WAIT_HIGH, stay until rx_s=1 and then go to IDLE, so a break condition yields exactly one frame_err.
REQ-023 SHALL pulse overrun together with Done if data_ready=1 at a good stop, with rx_data overwritten and data_ready staying 1.
REQ-024 SHALL clear data_ready on data_ack=1; if data_ack and a good stop coincide, data_ready SHALL stay 1 with no overrun.
REQ-025 SHALL ignore data_ack when data_ready=0.
REQ-026 SHALL keep Done, frame_err and overrun mutually exclusive except for Done+overrun.
REQ-027 SHALL leave rx_line activity outside IDLE/WAIT_HIGH without effect on the state sequence except at the sample points.
REQ-028 SHALL size counters to hold CLKS_PER_BIT-1 and DATA_BITS with no wrap.
REQ-029 SHALL use a default state branch that returns to IDLE.

Reset
REQ-030 SHALL, with rst=1 at a clk edge, force state IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data 0, and data_ready/Done/Busy/frame_err/overrun 0.
REQ-031 SHALL let rst mid-frame abort the frame with no flags; reception restarts only on a new falling edge after rst drops.
REQ-032 SHALL reach a defined state from a single reset cycle, with no initial-value dependence.

Verification (DATA_BITS=10, CLKS_PER_BIT=16, 16 clk per bit driven)
REQ-033 SHALL cover: frame 10'h2A5 with good stop -> one Done pulse 185-189 cycles after the start edge, rx_data=10'h2A5, data_ready=1, Busy low after.
REQ-034 SHALL cover: a 5-cycle low glitch on idle rx_line -> no Done/frame_err, Busy high about 10 cycles then low.
REQ-035 SHALL cover: frame 10'h155 with stop bit driven 0 and held low 40 bit times -> exactly one frame_err, no Done, rx_data unchanged, IDLE only after the line rises.
REQ-036 SHALL cover: two back-to-back frames 10'h001 and 10'h3FF with no data_ack -> second Done pulses with overrun=1, rx_data=10'h3FF.
REQ-037 SHALL cover: data_ack asserted on the same cycle as the second Done -> overrun=0, data_ready=1.
REQ-038 SHALL cover: rst pulse at bit 5 of a frame -> all outputs 0 the next cycle, no Done; a subsequent frame 10'h0F0 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver with 2-flop synchronizer, framing/overrun flags
module uart_rx #(
  parameter int DATA_BITS    = 10,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_line,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 Done,
  output logic                 Busy,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t               state_q;
  logic                 sync_q, rx_s_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q, rx_data_q;
  logic                 ready_q, done_q, ferr_q, ovr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q <= rx_line;
      rx_s_q <= sync_q;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (data_ack) ready_q <= 1'b0;
      case (state_q)
        IDLE: if (!rx_s_q) begin
          state_q <= START;
          cnt_q   <= '0;
          bit_q   <= '0;
        end
        START: if (cnt_q == HALF) begin
          cnt_q   <= '0;
          bit_q   <= '0;
          state_q <= rx_s_q ? IDLE : DATA;
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (cnt_q == FULL) begin
          cnt_q          <= '0;
          shift_q[bit_q] <= rx_s_q;
          bit_q          <= bit_q + 1'b1;
          if (bit_q == LAST) state_q <= STOP;
        end else cnt_q <= cnt_q + 1'b1;
        // a good stop overrides a same-cycle ack, so data_ready stays set with no overrun
        STOP: if (cnt_q == FULL) begin
          cnt_q <= '0;
          if (rx_s_q) begin
            rx_data_q <= shift_q;
            ready_q   <= 1'b1;
            done_q    <= 1'b1;
            ovr_q     <= ready_q && !data_ack;
            state_q   <= IDLE;
          end else begin
            ferr_q  <= 1'b1;
            state_q <= WAIT_HIGH;
          end
        end else cnt_q <= cnt_q + 1'b1;
        WAIT_HIGH: if (rx_s_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rx_data    = rx_data_q;
  assign data_ready = ready_q;
  assign Done       = done_q;
  assign Busy       = state_q != IDLE;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx (10 data bits, 16 clk per bit)
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic       data_ack = 1'b0;
  logic [9:0] rx_data;
  logic       data_ready, Done, Busy, frame_err, overrun;
  int checks = 0, errors = 0;
  int cyc = 0, n_done = 0, n_ferr = 0, n_ovr = 0, last_done_cyc = 0;
  logic last_ovr = 1'b0;
  uart_rx #(.DATA_BITS(10), .CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line), .data_ack(data_ack),
    .rx_data(rx_data), .data_ready(data_ready), .Done(Done), .Busy(Busy),
    .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (Done) begin
      n_done <= n_done + 1;
      last_ovr <= overrun;
      last_done_cyc <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (overrun) n_ovr <= n_ovr + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [9:0] d, input logic stop);
    logic [10:0] bits;
    bits = {d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_line = bits[i];
      tick(16);
    end
    rx_line = stop;
    tick(16);
  endtask
  initial begin
    int t0, d0, f0, o0;
    logic s_done, s_ovr, s_rdy;
    tick(2);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_outputs", {data_ready, Done, Busy, frame_err, overrun}, 0);
    rst = 1'b0;
    tick(4);
    // good frame and latency
    t0 = cyc; d0 = n_done; f0 = n_ferr;
    send_frame(10'h2A5, 1'b1);
    tick(16);
    chk("f1_done_count", n_done - d0, 1);
    chk("f1_latency_ok", 32'((last_done_cyc - t0) >= 185 && (last_done_cyc - t0) <= 189), 1);
    chk("f1_rx_data", 32'(rx_data), 32'h2A5);
    chk("f1_ready", 32'(data_ready), 1);
    chk("f1_busy_after", 32'(Busy), 0);
    chk("f1_no_ferr", n_ferr - f0, 0);
    data_ack = 1'b1; tick(1); data_ack = 1'b0;
    chk("ack_clears", 32'(data_ready), 0);
    data_ack = 1'b1; tick(1); data_ack = 1'b0;
    chk("ack_ignored", 32'(data_ready), 0);
    // glitch
    d0 = n_done; f0 = n_ferr;
    rx_line = 1'b0; tick(5); rx_line = 1'b1; tick(1);
    chk("glitch_busy", 32'(Busy), 1);
    tick(20);
    chk("glitch_idle", 32'(Busy), 0);
    chk("glitch_flags", (n_done - d0) + (n_ferr - f0), 0);
    // break: stop low and held
    d0 = n_done; f0 = n_ferr;
    send_frame(10'h155, 1'b0);
    tick(40 * 16 - 16);
    chk("brk_ferr_once", n_ferr - f0, 1);
    chk("brk_no_done", n_done - d0, 0);
    chk("brk_wait_busy", 32'(Busy), 1);
    chk("brk_rx_data", 32'(rx_data), 32'h2A5);
    chk("brk_ready", 32'(data_ready), 0);
    rx_line = 1'b1; tick(5);
    chk("brk_idle_after", 32'(Busy), 0);
    chk("brk_ferr_final", n_ferr - f0, 1);
    // back-to-back, no ack
    d0 = n_done; o0 = n_ovr;
    send_frame(10'h001, 1'b1);
    send_frame(10'h3FF, 1'b1);
    tick(16);
    chk("b2b_done_count", n_done - d0, 2);
    chk("b2b_ovr_count", n_ovr - o0, 1);
    chk("b2b_ovr_with_done", 32'(last_ovr), 1);
    chk("b2b_rx_data", 32'(rx_data), 32'h3FF);
    chk("b2b_ready", 32'(data_ready), 1);
    // ack on the same cycle as Done
    o0 = n_ovr;
    fork
      send_frame(10'h12C, 1'b1);
      begin
        tick(186);
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        s_done = Done; s_ovr = overrun; s_rdy = data_ready;
      end
    join
    tick(16);
    chk("ackc_done", 32'(s_done), 1);
    chk("ackc_ovr", 32'(s_ovr), 0);
    chk("ackc_ready", 32'(s_rdy), 1);
    chk("ackc_ovr_count", n_ovr - o0, 0);
    chk("ackc_rx_data", 32'(rx_data), 32'h12C);
    // reset mid-frame at bit 5 (bits 5..9 high so line stays idle-high afterwards)
    d0 = n_done;
    fork
      send_frame(10'h3E0, 1'b1);
      begin
        tick(103);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mrst_rx_data", 32'(rx_data), 0);
        chk("mrst_outputs", {data_ready, Done, Busy, frame_err, overrun}, 0);
      end
    join
    tick(16);
    chk("mrst_no_done", n_done - d0, 0);
    chk("mrst_idle", 32'(Busy), 0);
    d0 = n_done;
    send_frame(10'h0F0, 1'b1);
    tick(16);
    chk("post_done", n_done - d0, 1);
    chk("post_rx_data", 32'(rx_data), 32'h0F0);
    chk("post_ready", 32'(data_ready), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
